tw_horizontal_loader: RTL and testbench

Generates one group of four twiddle factors over the Goldilocks prime p = 2^64 − 2^32 + 1 and streams them into a twiddle ROM's stage-0 buffer. It is the write side of the ROM's `horizontal_data_in` / `ROM0_w` port. Each four-word burst is a geometric sequence: word k = init·base^k mod p. The words are computed serially with one modular multiplier, then emitted as a contiguous 4-cycle write burst. The burst must be contiguous because the ROM's write counter clears whenever `ROM0_w` drops.

---
 rtl/tw_pkg.sv | 20 ++
 rtl/goldilocks_mulmod.sv | 78 +++++++
 rtl/tw_horizontal_loader.sv | 137 +++++++++++++
 tb/tb_tw_horizontal_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tw_pkg.sv
// tw_pkg: shared definitions for the twiddle-factor generators.
//   GOLDILOCKS_P  modulus p = 2^64 - 2^32 + 1
//   EPS           2^32 - 1 (2^64 mod p), used by the folded reduction
//   tw_word_t     one field element
//   tw_ld_state_t loader FSM states
package tw_pkg;

  localparam logic [63:0] GOLDILOCKS_P = 64'hffffffff00000001;
  localparam logic [63:0] EPS          = 64'h00000000ffffffff;

  typedef logic [63:0] tw_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } tw_ld_state_t;

endpackage

// File: rtl/goldilocks_mulmod.sv
// goldilocks_mulmod: r = a*b mod p over the Goldilocks prime, fixed latency.
//   CLK, rst   clock, synchronous active-high reset (clears the pipeline)
//   a, b       operands, expected < p
//   in_valid   operands valid this cycle
//   out_valid  r valid, exactly MUL_LAT cycles after in_valid was sampled
//   r          reduced product in [0, p)
// The full product and reduction feed the first register; the remaining
// MUL_LAT-1 registers are a delay line that synthesis may retime into it.
module goldilocks_mulmod
  import tw_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic     CLK,
  input  logic     rst,
  input  tw_word_t a,
  input  tw_word_t b,
  input  logic     in_valid,
  output logic     out_valid,
  output tw_word_t r
);

  // 2^64 == 2^32 - 1 and 2^96 == -1 (mod p), so the 128-bit product folds as
  // lo - hh + hl*(2^32 - 1), with one correction per wrap.
  function automatic tw_word_t reduce(input logic [127:0] prod);
    logic [63:0] lo;
    logic [31:0] hh;
    logic [31:0] hl;
    logic [64:0] t_ext;
    logic [64:0] r_ext;
    logic [63:0] t;
    logic [63:0] m;
    logic [63:0] rr;
    lo    = prod[63:0];
    hh    = prod[127:96];
    hl    = prod[95:64];
    t_ext = {1'b0, lo} - {33'b0, hh};
    t     = t_ext[63:0];
    if (t_ext[64]) t = t + GOLDILOCKS_P;
    m     = {hl, 32'b0} - {32'b0, hl};
    r_ext = {1'b0, t} + {1'b0, m};
    rr    = r_ext[63:0];
    if (r_ext[64]) rr = rr + EPS;
    if (rr >= GOLDILOCKS_P) rr = rr - GOLDILOCKS_P;
    return rr;
  endfunction

  logic [127:0] prod_p0;
  tw_word_t     red_p0;
  tw_word_t     res_p [MUL_LAT];
  logic         vld_p [MUL_LAT];

  always_comb begin
    prod_p0 = {64'b0, a} * {64'b0, b};
    red_p0  = reduce(prod_p0);
  end

  // stage boundary: reduced product enters the latency line
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        res_p[i] <= '0;
        vld_p[i] <= 1'b0;
      end
    end else begin
      res_p[0] <= red_p0;
      vld_p[0] <= in_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        res_p[i] <= res_p[i-1];
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign r         = res_p[MUL_LAT-1];
  assign out_valid = vld_p[MUL_LAT-1];

endmodule

// File: rtl/tw_horizontal_loader.sv
// tw_horizontal_loader: computes word[k] = init * base^k mod p, k = 0..3,
// serially on one goldilocks_mulmod, then writes them to the twiddle ROM's
// stage-0 buffer as one contiguous 4-cycle burst.
//   CLK, rst             clock, synchronous active-high reset
//   start                request a burst (honoured in IDLE only)
//   base_in              common ratio, captured on an accepted start
//   init_in              first word (only when TW_LOADER_INIT_EN is defined;
//                        otherwise the first word is 1)
//   horizontal_data_out  ROM write data, 0 outside the burst
//   ROM0_w               ROM write strobe
//   busy                 cycle after accepted start .. last burst cycle
//   done                 one-cycle pulse after the burst
// The burst must not break: the ROM clears its write counter when ROM0_w drops.
module tw_horizontal_loader
  import tw_pkg::*;
#(
  parameter int P_WIDTH = 64,
  parameter int MUL_LAT = 3,
  parameter int WORDS   = 4
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               start,
  input  logic [P_WIDTH-1:0] base_in,
`ifdef TW_LOADER_INIT_EN
  input  logic [P_WIDTH-1:0] init_in,
`endif
  output logic [P_WIDTH-1:0] horizontal_data_out,
  output logic               ROM0_w,
  output logic               busy,
  output logic               done
);

  tw_ld_state_t state;
  logic [1:0]   cnt;
  tw_word_t     base_r;
  tw_word_t     word_rf [0:WORDS-1];

  tw_word_t seed;
  tw_word_t mul_a;
  tw_word_t mul_b;
  tw_word_t mul_r;
  logic     mul_iv;
  logic     mul_ov;

`ifdef TW_LOADER_INIT_EN
  assign seed = init_in;
`else
  assign seed = 64'h1;
`endif

  // The first multiply is issued on the accepting edge using the raw inputs;
  // later ones forward the product being captured so that each capture cycle
  // is also the next issue cycle.
  always_comb begin
    mul_a  = seed;
    mul_b  = base_in;
    mul_iv = 1'b0;
    if (state == IDLE) begin
      mul_iv = start;
    end else if (state == CALC) begin
      mul_a  = mul_r;
      mul_b  = base_r;
      mul_iv = mul_ov && (cnt != 2'(WORDS-1));
    end
  end

  goldilocks_mulmod #(
    .MUL_LAT(MUL_LAT)
  ) u_mulmod (
    .CLK      (CLK),
    .rst      (rst),
    .a        (mul_a),
    .b        (mul_b),
    .in_valid (mul_iv),
    .out_valid(mul_ov),
    .r        (mul_r)
  );

  // cnt is the word being computed in CALC and the word being written in BURST.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= 2'd0;
      base_r              <= '0;
      for (int i = 0; i < WORDS; i++) word_rf[i] <= '0;
      horizontal_data_out <= '0;
      ROM0_w              <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_r     <= base_in;
            word_rf[0] <= seed;
            cnt        <= 2'd1;
            busy       <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          if (mul_ov) begin
            word_rf[cnt] <= mul_r;
            if (cnt == 2'(WORDS-1)) begin
              cnt                 <= 2'd0;
              ROM0_w              <= 1'b1;
              horizontal_data_out <= word_rf[0];
              state               <= BURST;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        BURST: begin
          if (cnt == 2'(WORDS-1)) begin
            cnt                 <= 2'd0;
            ROM0_w              <= 1'b0;
            horizontal_data_out <= '0;
            busy                <= 1'b0;
            done                <= 1'b1;
            state               <= DONE;
          end else begin
            cnt                 <= cnt + 2'd1;
            horizontal_data_out <= word_rf[cnt + 2'd1];
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tw_horizontal_loader.sv
// tb_tw_horizontal_loader: directed, table-driven bench for tw_horizontal_loader
// at MUL_LAT = 1, 3, 5 plus a standalone goldilocks_mulmod instance.
// Cycle n of a transaction is the clock period that ends at edge n; the start
// request is held in cycle 0 and sampled at edge 0.
module tb_tw_horizontal_loader;
  import tw_pkg::*;

  typedef logic [3:0][63:0] quad_t;

  typedef struct {
    string    name;
    tw_word_t base;
    tw_word_t init;
    quad_t    exp;
  } bvec_t;

  typedef struct {
    tw_word_t a;
    tw_word_t b;
    tw_word_t r;
  } mvec_t;

  logic       CLK = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  tw_word_t   base_in;
`ifdef TW_LOADER_INIT_EN
  tw_word_t   init_in;
`endif
  tw_word_t   dout [3];
  logic       wr   [3];
  logic       bsy  [3];
  logic       dn   [3];

  tw_word_t   mm_a, mm_b, mm_r;
  logic       mm_iv, mm_ov;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  tw_horizontal_loader #(.MUL_LAT(1)) u_l1 (
    .CLK(CLK), .rst(rst), .start(start_v[0]), .base_in(base_in),
`ifdef TW_LOADER_INIT_EN
    .init_in(init_in),
`endif
    .horizontal_data_out(dout[0]), .ROM0_w(wr[0]), .busy(bsy[0]), .done(dn[0])
  );

  tw_horizontal_loader #(.MUL_LAT(3)) u_l3 (
    .CLK(CLK), .rst(rst), .start(start_v[1]), .base_in(base_in),
`ifdef TW_LOADER_INIT_EN
    .init_in(init_in),
`endif
    .horizontal_data_out(dout[1]), .ROM0_w(wr[1]), .busy(bsy[1]), .done(dn[1])
  );

  tw_horizontal_loader #(.MUL_LAT(5)) u_l5 (
    .CLK(CLK), .rst(rst), .start(start_v[2]), .base_in(base_in),
`ifdef TW_LOADER_INIT_EN
    .init_in(init_in),
`endif
    .horizontal_data_out(dout[2]), .ROM0_w(wr[2]), .busy(bsy[2]), .done(dn[2])
  );

  goldilocks_mulmod #(.MUL_LAT(2)) u_mm (
    .CLK(CLK), .rst(rst), .a(mm_a), .b(mm_b),
    .in_valid(mm_iv), .out_valid(mm_ov), .r(mm_r)
  );

  function automatic quad_t quad(input tw_word_t w0, input tw_word_t w1,
                                 input tw_word_t w2, input tw_word_t w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete transaction on instance idx with its full cycle profile.
  task automatic burst_check(input int idx, input int lat, input bvec_t v);
    int fw;
    logic ew;
    base_in = v.base;
`ifdef TW_LOADER_INIT_EN
    init_in = v.init;
`endif
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
    fw = 3 * lat + 1;
    for (int c = 1; c <= fw + 5; c++) begin
      ew = (c >= fw) && (c <= fw + 3);
      chk($sformatf("%s L%0d c%0d busy", v.name, lat, c), 64'(bsy[idx]), 64'(c <= fw + 3));
      chk($sformatf("%s L%0d c%0d wr", v.name, lat, c), 64'(wr[idx]), 64'(ew));
      chk($sformatf("%s L%0d c%0d data", v.name, lat, c), dout[idx],
          ew ? v.exp[c - fw] : 64'h0);
      chk($sformatf("%s L%0d c%0d done", v.name, lat, c), 64'(dn[idx]), 64'(c == fw + 4));
      tick();
    end
  endtask

  bvec_t bv [4];
  mvec_t mv [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected end within budget");
    $fatal(1);
  end

  initial begin
    bv[0].name = "pow2";  bv[0].base = 64'hfff7ffff00000001; bv[0].init = 64'h1;
    bv[0].exp  = quad(64'h1, 64'hfff7ffff00000001, 64'hfffffffeffffffc1, 64'h0200000000000000);
    bv[1].name = "scaled"; bv[1].base = 64'h2; bv[1].init = 64'h2;
`ifdef TW_LOADER_INIT_EN
    bv[1].exp  = quad(64'h2, 64'h4, 64'h8, 64'h10);
`else
    bv[1].exp  = quad(64'h1, 64'h2, 64'h4, 64'h8);
`endif
    bv[2].name = "pminus1"; bv[2].base = 64'hffffffff00000000; bv[2].init = 64'h1;
    bv[2].exp  = quad(64'h1, 64'hffffffff00000000, 64'h1, 64'hffffffff00000000);
    bv[3].name = "zero";  bv[3].base = 64'h0; bv[3].init = 64'h1;
    bv[3].exp  = quad(64'h1, 64'h0, 64'h0, 64'h0);

    mv[0] = '{64'hffffffff00000000, 64'hffffffff00000000, 64'h1};
    mv[1] = '{64'h0000000100000000, 64'h0000000100000000, 64'h00000000ffffffff};
    mv[2] = '{64'hffffffff00000000, 64'h2, 64'hfffffffeffffffff};
    mv[3] = '{64'h0, 64'h123456789abcdef0, 64'h0};
    mv[4] = '{64'h8000000000000000, 64'h2, 64'h00000000ffffffff};
    mv[5] = '{64'hffffffff00000000, 64'hfffffffeffffffff, 64'h2};

    rst = 1'b1; start_v = 3'b000; base_in = 64'h5;
`ifdef TW_LOADER_INIT_EN
    init_in = 64'h7;
`endif
    mm_a = '0; mm_b = '0; mm_iv = 1'b0;
    tick(); tick();
    start_v = 3'b111;           // start together with reset: reset must win
    tick();
    rst = 1'b0; start_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset i%0d busy", i), 64'(bsy[i]), 64'h0);
      chk($sformatf("reset i%0d wr", i), 64'(wr[i]), 64'h0);
      chk($sformatf("reset i%0d data", i), dout[i], 64'h0);
      chk($sformatf("reset i%0d done", i), 64'(dn[i]), 64'h0);
    end
    chk("reset mm valid", 64'(mm_ov), 64'h0);
    tick();
    chk("rst-wins busy", 64'(bsy[1]), 64'h0);

    // modular multiplier directed vectors
    for (int i = 0; i < 6; i++) begin
      int k;
      mm_a = mv[i].a; mm_b = mv[i].b; mm_iv = 1'b1;
      tick();
      mm_iv = 1'b0;
      k = 0;
      while (!mm_ov && k < 6) begin
        tick();
        k++;
      end
      chk($sformatf("mulmod v%0d latency", i), 64'(k), 64'h1);
      chk($sformatf("mulmod v%0d r", i), mm_r, mv[i].r);
      tick();
    end

    // table of bursts at MUL_LAT = 3
    for (int i = 0; i < 4; i++) burst_check(1, 3, bv[i]);

    // latency sweep with the power-of-two vector
    burst_check(0, 1, bv[0]);
    burst_check(2, 5, bv[0]);

    // start while busy, start in DONE (ignored), start in next IDLE (accepted)
    begin
      int nw, nd;
      logic ew;
      nw = 0; nd = 0;
      base_in = bv[0].base;
`ifdef TW_LOADER_INIT_EN
      init_in = 64'h1;
`endif
      for (int c = 0; c <= 31; c++) begin
        ew = (c >= 10 && c <= 13) || (c >= 25 && c <= 28);
        chk($sformatf("busy-seq c%0d busy", c), 64'(bsy[1]),
            64'((c >= 1 && c <= 13) || (c >= 16 && c <= 28)));
        chk($sformatf("busy-seq c%0d wr", c), 64'(wr[1]), 64'(ew));
        chk($sformatf("busy-seq c%0d done", c), 64'(dn[1]), 64'(c == 14 || c == 29));
        if (ew) chk($sformatf("busy-seq c%0d data", c), dout[1],
                    bv[0].exp[(c >= 25) ? c - 25 : c - 10]);
        nw += int'(wr[1]);
        nd += int'(dn[1]);
        start_v[1] = (c == 0 || c == 3 || c == 11 || c == 14 || c == 15);
        tick();
      end
      start_v[1] = 1'b0;
      chk("busy-seq write count", 64'(nw), 64'h8);
      chk("busy-seq done count", 64'(nd), 64'h2);
    end

    // reset at the second burst cycle, then a clean burst
    base_in = bv[0].base;
    for (int c = 0; c <= 16; c++) begin
      if (c == 11) begin
        chk("rst-mid c11 wr", 64'(wr[1]), 64'h1);
        chk("rst-mid c11 data", dout[1], bv[0].exp[1]);
      end
      if (c >= 12) begin
        chk($sformatf("rst-mid c%0d wr", c), 64'(wr[1]), 64'h0);
        chk($sformatf("rst-mid c%0d busy", c), 64'(bsy[1]), 64'h0);
        chk($sformatf("rst-mid c%0d done", c), 64'(dn[1]), 64'h0);
        chk($sformatf("rst-mid c%0d data", c), dout[1], 64'h0);
      end
      start_v[1] = (c == 0);
      rst = (c == 11);
      tick();
    end
    rst = 1'b0;
    burst_check(1, 3, bv[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
